// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-side load/store unit: memop encodings,
// MMIO map, LED width and the load-extension / fault helpers.
package dmem_lsu_pkg;

   localparam logic [2:0] MEMOP_B  = 3'b000;
   localparam logic [2:0] MEMOP_H  = 3'b001;
   localparam logic [2:0] MEMOP_W  = 3'b010;
   localparam logic [2:0] MEMOP_BU = 3'b100;
   localparam logic [2:0] MEMOP_HU = 3'b101;

   localparam logic [31:0] MMIO_CNT_ADDR = 32'hF000_0000;
   localparam logic [31:0] MMIO_LED_ADDR = 32'hF000_0004;
   localparam int          LED_W         = 16;

   // Illegal ops and misaligned halfword/word accesses fault.
   function automatic logic access_fault(input logic [2:0] op, input logic [1:0] lane);
      logic f;
      case (op)
         MEMOP_B, MEMOP_BU: f = 1'b0;
         MEMOP_H, MEMOP_HU: f = lane[0];
         MEMOP_W:           f = (lane != 2'b00);
         default:           f = 1'b1;
      endcase
      return f;
   endfunction

   // Extract the addressed byte/halfword and sign- or zero-extend it.
   function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] lane,
                                               input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = 8'(word >> {lane, 3'b000});
      h = lane[1] ? word[31:16] : word[15:0];
      case (op)
         MEMOP_B:  r = {{24{b[7]}}, b};
         MEMOP_BU: r = {24'h0, b};
         MEMOP_H:  r = {{16{h[15]}}, h};
         MEMOP_HU: r = {16'h0, h};
         default:  r = word;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dmem_lsu_lane_ram.sv
// Single-port synchronous RAM, four byte lanes with individual write
// enables, registered read, no reset (contents survive reset).
module dmem_lane_ram #(
   parameter int AW = 15
) (
   input  logic          clock,
   input  logic [AW-1:0] addr,
   input  logic [3:0]    we,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [2**AW];

   // Byte-lane writes and registered read (read returns pre-write data).
   always_ff @(posedge clock) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/dmem_lsu.sv
// Data load/store unit with byte-lane RAM, registered one-cycle loads,
// sticky fault capture. Optional MMIO (cycle counter, LED register) is
// compiled in with `define DMEM_MMIO_EN.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int WORD_AW = 15
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      dmemaddr,
   input  logic [31:0]      dmemdatain,
   input  logic [2:0]       dmemop,
   input  logic             dmemwe,
   input  logic             dmemre,
   output logic [31:0]      dmemdataout,
   output logic             rvalid,
   output logic             misalign_err,
   output logic [31:0]      err_addr,
   input  logic             err_clr,
   output logic [LED_W-1:0] led
);

   logic        store_req, load_req, fault, is_mmio;
   logic [3:0]  lane_sel, ram_we;
   logic [31:0] wdata_rep, ram_rdata, mmio_rdata;
   logic [2:0]  ld_op;
   logic [1:0]  ld_lane;
   logic        ld_fault, ld_mmio;
   logic [31:0] mmio_q, out_hold, ld_word, ld_ext;

   assign store_req = dmemwe;
   assign load_req  = dmemre & ~dmemwe;
   assign fault     = access_fault(dmemop, dmemaddr[1:0]);

   // Lane selection and data replication for store merge.
   always_comb begin
      lane_sel  = 4'b0000;
      wdata_rep = dmemdatain;
      case (dmemop)
         MEMOP_B, MEMOP_BU: begin
            lane_sel  = 4'b0001 << dmemaddr[1:0];
            wdata_rep = {4{dmemdatain[7:0]}};
         end
         MEMOP_H, MEMOP_HU: begin
            lane_sel  = dmemaddr[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{dmemdatain[15:0]}};
         end
         default: lane_sel = 4'b1111;
      endcase
   end

   assign ram_we = (store_req && !fault && !is_mmio) ? lane_sel : 4'b0000;

   dmem_lane_ram #(.AW(WORD_AW)) u_ram (
      .clock (clock),
      .addr  (dmemaddr[WORD_AW+1:2]),
      .we    (ram_we),
      .wdata (wdata_rep),
      .rdata (ram_rdata)
   );

`ifdef DMEM_MMIO_EN
   logic [31:0]      cycle_cnt;
   logic [LED_W-1:0] led_q;

   assign is_mmio = (dmemaddr[31:28] == 4'hF);
   assign led     = led_q;

   // MMIO read mux; unmapped F-region addresses read zero.
   always_comb begin
      mmio_rdata = 32'h0;
      if (dmemaddr[31:2] == MMIO_CNT_ADDR[31:2])      mmio_rdata = cycle_cnt;
      else if (dmemaddr[31:2] == MMIO_LED_ADDR[31:2]) mmio_rdata = {{(32-LED_W){1'b0}}, led_q};
   end

   // Free-running cycle counter and LED register (low two byte lanes only).
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cycle_cnt <= 32'h0;
         led_q     <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (store_req && !fault && dmemaddr[31:2] == MMIO_LED_ADDR[31:2]) begin
            if (lane_sel[0]) led_q[7:0]  <= wdata_rep[7:0];
            if (lane_sel[1]) led_q[15:8] <= wdata_rep[15:8];
         end
      end
   end
`else
   assign is_mmio    = 1'b0;
   assign mmio_rdata = 32'h0;
   assign led        = '0;
`endif

   // Load pipeline register: op, lane, fault and MMIO data for next cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rvalid   <= 1'b0;
         ld_op    <= MEMOP_W;
         ld_lane  <= 2'b00;
         ld_fault <= 1'b0;
         ld_mmio  <= 1'b0;
         mmio_q   <= 32'h0;
      end else begin
         rvalid <= load_req;
         if (load_req) begin
            ld_op    <= dmemop;
            ld_lane  <= dmemaddr[1:0];
            ld_fault <= fault;
            ld_mmio  <= is_mmio;
            mmio_q   <= mmio_rdata;
         end
      end
   end

   assign ld_word     = ld_mmio ? mmio_q : ram_rdata;
   assign ld_ext      = ld_fault ? 32'h0 : load_extend(ld_op, ld_lane, ld_word);
   assign dmemdataout = rvalid ? ld_ext : out_hold;

   // Hold the last delivered load result while rvalid is low.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)       out_hold <= 32'h0;
      else if (rvalid) out_hold <= ld_ext;
   end

   // Sticky fault capture; a clear on the same edge drops the new fault.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         misalign_err <= 1'b0;
         err_addr     <= 32'h0;
      end else if (err_clr) begin
         misalign_err <= 1'b0;
         err_addr     <= 32'h0;
      end else if ((store_req || load_req) && fault && !misalign_err) begin
         misalign_err <= 1'b1;
         err_addr     <= dmemaddr;
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu (MMIO section follows DMEM_MMIO_EN).
module tb_dmem_lsu;
   import dmem_lsu_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] dmemaddr = 32'h0;
   logic [31:0] dmemdatain = 32'h0;
   logic [2:0]  dmemop = MEMOP_W;
   logic        dmemwe = 1'b0;
   logic        dmemre = 1'b0;
   logic        err_clr = 1'b0;
   logic [31:0] dmemdataout;
   logic        rvalid;
   logic        misalign_err;
   logic [31:0] err_addr;
   logic [15:0] led;

   int checks = 0;
   int errors = 0;

   dmem_lsu dut (
      .clock(clock), .reset(reset), .dmemaddr(dmemaddr), .dmemdatain(dmemdatain),
      .dmemop(dmemop), .dmemwe(dmemwe), .dmemre(dmemre), .dmemdataout(dmemdataout),
      .rvalid(rvalid), .misalign_err(misalign_err), .err_addr(err_addr),
      .err_clr(err_clr), .led(led)
   );

   always #5 clock = ~clock;

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
      @(negedge clock);
      dmemaddr = a; dmemdatain = d; dmemop = op; dmemwe = 1'b1; dmemre = 1'b0;
      @(posedge clock); #1;
      dmemwe = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [2:0] op,
                          output logic [31:0] d, output logic v);
      @(negedge clock);
      dmemaddr = a; dmemop = op; dmemre = 1'b1; dmemwe = 1'b0;
      @(posedge clock); #1;
      dmemre = 1'b0;
      d = dmemdataout; v = rvalid;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if ({dmemdataout, rvalid, misalign_err, err_addr, led} !== 82'h0) begin
         errors++;
         $display("FAIL reset: out=%h rvalid=%b err=%b err_addr=%h led=%h, required all 0",
                  dmemdataout, rvalid, misalign_err, err_addr, led);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_bytes;
      logic [31:0] d, exp_d[5], addrs[5];
      logic [2:0]  ops[5];
      logic        v;
      addrs = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h103};
      ops   = '{MEMOP_B, MEMOP_B, MEMOP_B, MEMOP_B, MEMOP_BU};
      exp_d = '{32'h0000_0002, 32'h0000_007F, 32'hFFFF_FFF1, 32'hFFFF_FF80, 32'h0000_0080};
      do_store(32'h100, 32'h80F1_7F02, MEMOP_W);
      for (int i = 0; i < 5; i++) begin
         do_load(addrs[i], ops[i], d, v);
         checks++;
         if (v !== 1'b1 || d !== exp_d[i]) begin
            errors++;
            $display("FAIL byte_load[%0d]: got %h rvalid=%b, required %h rvalid=1", i, d, v, exp_d[i]);
         end
      end
      @(posedge clock); #1;
      checks++;
      if (rvalid !== 1'b0 || dmemdataout !== 32'h0000_0080) begin
         errors++;
         $display("FAIL hold: got %h rvalid=%b, required 00000080 rvalid=0", dmemdataout, rvalid);
      end
   endtask

   task automatic test_halfwords;
      logic [31:0] d;
      logic        v;
      do_store(32'h100, 32'h1122_3344, MEMOP_W);
      do_store(32'h102, 32'h0000_BEEF, MEMOP_H);
      do_load(32'h100, MEMOP_W, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'hBEEF_3344) begin
         errors++;
         $display("FAIL sh_merge: got %h rvalid=%b, required beef3344", d, v);
      end
      do_load(32'h102, MEMOP_H, d, v);
      checks++;
      if (d !== 32'hFFFF_BEEF) begin
         errors++;
         $display("FAIL lh: got %h, required ffffbeef", d);
      end
      do_load(32'h102, MEMOP_HU, d, v);
      checks++;
      if (d !== 32'h0000_BEEF) begin
         errors++;
         $display("FAIL lhu: got %h, required 0000beef", d);
      end
   endtask

   task automatic test_misalign;
      logic [31:0] d;
      logic        v;
      do_store(32'h101, 32'hDEAD_BEEF, MEMOP_W);
      checks++;
      if (misalign_err !== 1'b1 || err_addr !== 32'h101) begin
         errors++;
         $display("FAIL misalign_flag: err=%b addr=%h, required 1 00000101", misalign_err, err_addr);
      end
      do_load(32'h100, MEMOP_W, d, v);
      checks++;
      if (d !== 32'hBEEF_3344) begin
         errors++;
         $display("FAIL faulting_store_wrote: got %h, required beef3344", d);
      end
      do_load(32'h203, MEMOP_H, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h0 || err_addr !== 32'h101) begin
         errors++;
         $display("FAIL second_fault: data=%h rvalid=%b err_addr=%h, required 0 1 00000101", d, v, err_addr);
      end
      @(negedge clock); err_clr = 1'b1;
      @(posedge clock); #1; err_clr = 1'b0;
      checks++;
      if (misalign_err !== 1'b0 || err_addr !== 32'h0) begin
         errors++;
         $display("FAIL err_clr: err=%b addr=%h, required 0 0", misalign_err, err_addr);
      end
      @(negedge clock);
      err_clr = 1'b1; dmemaddr = 32'h102; dmemop = MEMOP_W; dmemre = 1'b1;
      @(posedge clock); #1;
      err_clr = 1'b0; dmemre = 1'b0;
      checks++;
      if (misalign_err !== 1'b0 || err_addr !== 32'h0) begin
         errors++;
         $display("FAIL clr_wins: err=%b addr=%h, required 0 0", misalign_err, err_addr);
      end
      do_load(32'h100, 3'b011, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h0 || misalign_err !== 1'b1 || err_addr !== 32'h100) begin
         errors++;
         $display("FAIL illegal_op: data=%h rvalid=%b err=%b addr=%h, required 0 1 1 00000100",
                  d, v, misalign_err, err_addr);
      end
      @(negedge clock); err_clr = 1'b1;
      @(posedge clock); #1; err_clr = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [31:0] d;
      logic        v;
      @(negedge clock);
      dmemaddr = 32'h200; dmemdatain = 32'h0000_CAFE; dmemop = MEMOP_W;
      dmemwe = 1'b1; dmemre = 1'b1;
      @(posedge clock); #1;
      dmemwe = 1'b0; dmemre = 1'b0;
      checks++;
      if (rvalid !== 1'b0) begin
         errors++;
         $display("FAIL collision_rvalid: got %b, required 0", rvalid);
      end
      do_load(32'h200, MEMOP_W, d, v);
      checks++;
      if (d !== 32'h0000_CAFE) begin
         errors++;
         $display("FAIL collision_store: got %h, required 0000cafe", d);
      end
      do_store(32'h300, 32'h1234_5678, MEMOP_W);
      do_load(32'h300, MEMOP_W, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h1234_5678) begin
         errors++;
         $display("FAIL raw: got %h rvalid=%b, required 12345678", d, v);
      end
   endtask

   task automatic test_reset_mid_load;
      logic [31:0] d;
      logic        v;
      do_load(32'h100, MEMOP_W, d, v);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (rvalid !== 1'b0 || dmemdataout !== 32'h0 || led !== 16'h0) begin
         errors++;
         $display("FAIL reset_mid_load: rvalid=%b out=%h led=%h, required 0 0 0", rvalid, dmemdataout, led);
      end
      @(negedge clock); reset = 1'b0;
      do_load(32'h300, MEMOP_W, d, v);
      checks++;
      if (d !== 32'h1234_5678) begin
         errors++;
         $display("FAIL ram_kept: got %h, required 12345678", d);
      end
   endtask

   task automatic test_mmio;
      logic [31:0] d, d2;
      logic        v;
      do_store(32'hF000_0005, 32'h0000_00A5, MEMOP_B);
`ifdef DMEM_MMIO_EN
      checks++;
      if (led !== 16'hA500) begin
         errors++;
         $display("FAIL led_sb: got %h, required a500", led);
      end
      do_load(32'hF000_0004, MEMOP_W, d, v);
      checks++;
      if (d !== 32'h0000_A500) begin
         errors++;
         $display("FAIL led_read: got %h, required 0000a500", d);
      end
      do_load(32'hF000_0000, MEMOP_W, d, v);
      repeat (3) @(posedge clock);
      do_load(32'hF000_0000, MEMOP_W, d2, v);
      checks++;
      if (d2 - d !== 32'd4) begin
         errors++;
         $display("FAIL counter_delta: got %0d, required 4", d2 - d);
      end
`else
      checks++;
      if (led !== 16'h0) begin
         errors++;
         $display("FAIL led_absent: got %h, required 0000", led);
      end
      do_load(32'h0000_0005, MEMOP_BU, d, v);
      checks++;
      if (d !== 32'h0000_00A5) begin
         errors++;
         $display("FAIL f_region_wrap: got %h, required 000000a5", d);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_bytes();
      test_halfwords();
      test_misalign();
      test_back_to_back();
      test_reset_mid_load();
      test_mmio();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
